// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: width, funct3 encodings, FSM states.
package muldiv_pkg;

  localparam int unsigned WIDTH = 32;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } muldiv_state_e;

  // rs1 is treated as signed for these ops
  function automatic logic rs1_signed(muldiv_op_e op);
    return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
  endfunction

  // rs2 is treated as signed for these ops
  function automatic logic rs2_signed(muldiv_op_e op);
    return op inside {OpMul, OpMulh, OpDiv, OpRem};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One 64-bit accumulator serves both shift-add
// multiplication and restoring division on operand magnitudes; signs are reapplied in DONE.
module muldiv_unit #(
  parameter int unsigned WIDTH = muldiv_pkg::WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs1_data_i,
  input  logic [WIDTH-1:0] rs2_data_i,
  input  logic [4:0]       rd_addr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [4:0]       rd_addr_o
);
  import muldiv_pkg::*;

  localparam int unsigned AccW = 2 * WIDTH;

  muldiv_state_e    state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  muldiv_op_e       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             res_neg_q, res_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       rd_out_q, rd_out_d;
  logic             done_q, done_d;

  muldiv_op_e       op_in;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf;

  logic [WIDTH:0]   mul_sum;
  logic [AccW-1:0]  mul_step;
  logic [WIDTH:0]   div_diff;
  logic [AccW-1:0]  div_step;

  logic [AccW-1:0]  prod;
  logic [WIDTH-1:0] quot, rem, final_res;

  // Decode incoming request: magnitudes, result signs and the one-cycle special cases
  always_comb begin
    op_in    = muldiv_op_e'(op_i);
    a_neg    = rs1_signed(op_in) & rs1_data_i[WIDTH-1];
    b_neg    = rs2_signed(op_in) & rs2_data_i[WIDTH-1];
    a_mag    = a_neg ? -rs1_data_i : rs1_data_i;
    b_mag    = b_neg ? -rs2_data_i : rs2_data_i;
    div_zero = op_i[2] && (rs2_data_i == '0);
    // DIV/REM only (signed divide ops have funct3[0] clear)
    div_ovf  = op_i[2] && !op_i[0] && (rs1_data_i == {1'b1, {(WIDTH-1){1'b0}}})
               && (rs2_data_i == '1);
  end

  // One iteration of shift-add multiply or restoring divide on the accumulator
  always_comb begin
    mul_sum  = {1'b0, acc_q[AccW-1:WIDTH]} + {1'b0, opb_q};
    mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[AccW-1:1]};
    // Remainder stays below divisor, so the shifted-out top bit is always zero
    div_diff = {1'b0, acc_q[AccW-2:WIDTH-1]} - {1'b0, opb_q};
    div_step = div_diff[WIDTH] ? {acc_q[AccW-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  // Sign correction and result selection applied in DONE
  always_comb begin
    prod = res_neg_q ? -acc_q : acc_q;
    quot = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = rem_neg_q ? -acc_q[AccW-1:WIDTH] : acc_q[AccW-1:WIDTH];
    unique case (op_q)
      OpMul:                     final_res = prod[WIDTH-1:0];
      OpMulh, OpMulhsu, OpMulhu: final_res = prod[AccW-1:WIDTH];
      OpDiv, OpDivu:             final_res = quot;
      OpRem, OpRemu:             final_res = rem;
      default:                   final_res = quot;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: special divides skip CALC entirely
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = (div_zero || div_ovf) ? StDone : StCalc;
      end
      StCalc: begin
        if (cnt_q == 5'd31) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o = (state_q == StCalc) || (state_q == StDone);
  end

  // Datapath next-state
  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d  = op_in;
          rd_d  = rd_addr_i;
          cnt_d = '0;
          if (div_zero) begin
            // Final raw values: remainder = rs1 as-is, quotient all ones, no sign fix
            acc_d     = {rs1_data_i, {WIDTH{1'b1}}};
            opb_d     = '0;
            res_neg_d = 1'b0;
            rem_neg_d = 1'b0;
          end else if (div_ovf) begin
            acc_d     = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
            opb_d     = '0;
            res_neg_d = 1'b0;
            rem_neg_d = 1'b0;
          end else begin
            acc_d     = {{WIDTH{1'b0}}, a_mag};
            opb_d     = b_mag;
            res_neg_d = a_neg ^ b_neg;
            rem_neg_d = a_neg;
          end
        end
      end
      StCalc: begin
        acc_d = op_q[2] ? div_step : mul_step;
        cnt_d = cnt_q + 5'd1;
      end
      StDone: begin
        result_d = final_res;
        rd_out_d = rd_q;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q     <= '0;
      op_q      <= OpMul;
      rd_q      <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
      done_q    <= done_d;
    end
  end

  assign done_o    = done_q;
  assign result_o  = result_q;
  assign rd_addr_o = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table run back-to-back, plus reset-abort sequence.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_addr_i  (rd_addr_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    muldiv_op_e  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] want;
    int          lat;
  } vec_t;

  vec_t        vecs [20];
  int          total = 0;
  int          bad = 0;
  logic [31:0] prev_exp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Start at #1 after a rising edge with the unit idle; returns in the done_o cycle.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] want,
                        input int lat);
    int n;
    bit seen;
    op_i       = op;
    rs1_data_i = a;
    rs2_data_i = b;
    rd_addr_i  = tag;
    start_i    = 1'b1;
    @(posedge clk_i);
    #1;
    start_i    = 1'b0;
    op_i       = 3'($urandom);
    rs1_data_i = $urandom;
    rs2_data_i = $urandom;
    rd_addr_i  = 5'($urandom);
    check({name, " busy after start"}, 32'(busy_o), 32'd1);
    check({name, " done low after start"}, 32'(done_o), 32'd0);
    check({name, " previous result held"}, result_o, prev_exp);
    n    = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk_i);
      #1;
      n++;
      seen = done_o;
    end
    check({name, " latency"}, 32'(n), 32'(lat));
    check({name, " result"}, result_o, want);
    check({name, " rd tag"}, 32'(rd_addr_o), 32'(tag));
    check({name, " busy low with done"}, 32'(busy_o), 32'd0);
    prev_exp = want;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    vecs[0]  = '{OpMul,    32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{OpMulh,   32'h80000000,  32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{OpMulhu,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[3]  = '{OpMulhsu, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[4]  = '{OpDiv,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{OpRem,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{OpDivu,   32'd100,       32'd7,        32'd14,       33};
    vecs[7]  = '{OpRemu,   32'd100,       32'd7,        32'd2,        33};
    vecs[8]  = '{OpDivu,   32'd5,         32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{OpRem,    32'd5,         32'd0,        32'd5,        1};
    vecs[10] = '{OpDiv,    32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{OpRem,    32'h80000000,  32'hFFFFFFFF, 32'd0,        1};
    vecs[12] = '{OpMul,    32'h12345678,  32'h10,       32'h23456780, 33};
    vecs[13] = '{OpDiv,    32'd100,       32'hFFFFFFF9, 32'hFFFFFFF2, 33};
    vecs[14] = '{OpRem,    32'hFFFFFF9C,  32'd7,        32'hFFFFFFFE, 33};
    vecs[15] = '{OpDivu,   32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF, 33};
    vecs[16] = '{OpRem,    32'hFFFFFFF9,  32'd0,        32'hFFFFFFF9, 1};
    vecs[17] = '{OpMulhu,  32'h80000000,  32'd2,        32'd1,        33};
    vecs[18] = '{OpDivu,   32'h80000000,  32'hFFFFFFFF, 32'd0,        33};
    vecs[19] = '{OpMulh,   32'hFFFFFFFF,  32'd7,        32'hFFFFFFFF, 33};

    rst_i      = 1'b1;
    start_i    = 1'b0;
    op_i       = '0;
    rs1_data_i = '0;
    rs2_data_i = '0;
    rd_addr_i  = '0;
    #2;
    rst_i = 1'b0;
    #1;
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    check("reset result", result_o, 32'd0);
    check("reset rd", 32'(rd_addr_o), 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    // Back-to-back: each op starts in the done_o cycle of the previous one
    for (int i = 0; i < 20; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 3),
             vecs[i].want, vecs[i].lat);
    end
    @(posedge clk_i);
    #1;
    check("final done pulse width", 32'(done_o), 32'd0);
    check("final result held", result_o, prev_exp);

    // Start ignored while busy, then reset at CALC step 10 aborts with no done
    op_i       = OpMul;
    rs1_data_i = 32'd3;
    rs2_data_i = 32'd5;
    rd_addr_i  = 5'd9;
    start_i    = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    @(posedge clk_i);
    #1;
    start_i    = 1'b1;
    op_i       = OpDivu;
    rs2_data_i = 32'd0;
    pulses     = 0;
    for (int k = 2; k <= 10; k++) begin
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      if (done_o) pulses++;
    end
    check("abort busy before reset", 32'(busy_o), 32'd1);
    check("mid-op start ignored", 32'(pulses), 32'd0);
    rst_i = 1'b0;
    #1;
    check("abort busy drops", 32'(busy_o), 32'd0);
    check("abort done low", 32'(done_o), 32'd0);
    check("abort result cleared", result_o, 32'd0);
    check("abort rd cleared", 32'(rd_addr_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk_i);
      #1;
      if (done_o) pulses++;
    end
    check("no done after abort", 32'(pulses), 32'd0);

    // Fresh operation after reset
    prev_exp = 32'd0;
    run_op("post-reset divu", OpDivu, 32'd1000, 32'd10, 5'd17, 32'd100, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
